// File: rtl/cpu_pkg.sv
// cpu_pkg: shared display modes, glyph codes and glyph-to-segment decoding
package cpu_pkg;
  typedef enum logic [1:0] {DISP_UDEC, DISP_SDEC, DISP_HEX, DISP_BLANK} display_mode_e;
  typedef logic [4:0] glyph_t;
  localparam glyph_t GLYPH_MINUS = 5'h10;
  localparam glyph_t GLYPH_BLANK = 5'h11;
  function automatic int dec_digits(input int w);
    longint v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
  function automatic logic [6:0] glyph_to_seg(input glyph_t g);
    case (g)
      5'h00:       return 7'h3F;
      5'h01:       return 7'h06;
      5'h02:       return 7'h5B;
      5'h03:       return 7'h4F;
      5'h04:       return 7'h66;
      5'h05:       return 7'h6D;
      5'h06:       return 7'h7D;
      5'h07:       return 7'h07;
      5'h08:       return 7'h7F;
      5'h09:       return 7'h6F;
      5'h0A:       return 7'h77;
      5'h0B:       return 7'h7C;
      5'h0C:       return 7'h39;
      5'h0D:       return 7'h5E;
      5'h0E:       return 7'h79;
      5'h0F:       return 7'h71;
      GLYPH_MINUS: return 7'h40;
      default:     return 7'h00;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_scanner_double_dabble.sv
// double_dabble: sequential binary-to-BCD converter, one shift-add-3 step per cycle
module double_dabble #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] bcd
);
  localparam int CW = $clog2(W + 1);
  logic [4*N+W-1:0] sr, sr_step;
  logic [CW-1:0] cnt;
  // add 3 to every BCD nibble of 5 or more, then shift the whole register left
  always_comb begin
    sr_step = sr;
    for (int i = 0; i < N; i++)
      if (sr[W+4*i +: 4] >= 4'd5) sr_step[W+4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
    sr_step = sr_step << 1;
  end
  // the first step is a plain shift (BCD field is zero), so it is folded into start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sr <= {{(4*N){1'b0}}, bin} << 1;
      cnt <= CW'(1);
      busy <= 1'b1;
    end else if (busy) begin
      sr <= sr_step;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  assign done = busy && cnt == CW'(W - 1);
  assign bcd = sr_step[4*N+W-1 -: 4*N];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: captures a value, renders it as decimal or hex glyphs, and scans them onto a multiplexed display
module seven_seg_scanner
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int GUARD       = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic [DIGITS-1:0]     digit,
  output logic [7:0]            segments
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = dec_digits(W);
  localparam int HN = (W + 3) / 4;
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  if (W < 2 || W > 16 || DIGITS < N + 1 || REFRESH_DIV < 4 || GUARD >= REFRESH_DIV) begin : g_param_check
    $error("seven_seg_scanner: unsupported parameter combination");
  end
  typedef enum logic {IDLE, CONVERT} state_e;
  state_e state, state_nxt;
  display_mode_e md;
  logic is_neg, neg_q, start, commit, dd_busy, dd_done, lit;
  logic [W-1:0] mag;
  logic [4*HN-1:0] vx;
  logic [4*N-1:0] dd_bcd;
  logic [SW-1:0] slot;
  logic [IW-1:0] idx;
  logic [DIGITS-1:0] dig_raw;
  logic [7:0] seg_raw;
  glyph_t fb [DIGITS];
  glyph_t imm_fb [DIGITS];
  glyph_t dec_fb [DIGITS];
  int msd;
  assign md = display_mode_e'(mode);
  assign is_neg = md == DISP_SDEC && value[W-1];
  assign mag = is_neg ? -value : value;
  assign vx = (4*HN)'(value);
  assign start = load && (md == DISP_UDEC || md == DISP_SDEC);
  assign commit = state == CONVERT && dd_done && !load;
  assign busy = state == CONVERT;
  double_dabble #(.W(W), .N(N)) u_dd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag),
    .busy  (dd_busy),
    .done  (dd_done),
    .bcd   (dd_bcd)
  );
  // any load restarts or aborts; a conversion ends on its final step
  always_comb begin
    state_nxt = state;
    if (load) state_nxt = start ? CONVERT : IDLE;
    else if (state == CONVERT && (dd_done || !dd_busy)) state_nxt = IDLE;
  end
  // state register and the sign captured alongside the magnitude
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      neg_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) neg_q <= is_neg;
    end
  // hex and blank frames are written straight from the load inputs
  always_comb begin
    for (int i = 0; i < DIGITS; i++) imm_fb[i] = GLYPH_BLANK;
    if (md == DISP_HEX)
      for (int i = 0; i < HN; i++) imm_fb[i] = {1'b0, vx[4*i +: 4]};
  end
  // decimal frame: leading zeros blanked, minus just left of the top numeral
  always_comb begin
    msd = 0;
    for (int i = 1; i < N; i++) if (dd_bcd[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < DIGITS; i++) dec_fb[i] = GLYPH_BLANK;
    for (int i = 0; i < N; i++) if (i <= msd) dec_fb[i] = {1'b0, dd_bcd[4*i +: 4]};
    for (int i = 1; i <= N; i++) if (neg_q && i == msd + 1) dec_fb[i] = GLYPH_MINUS;
  end
  // frame buffer changes only as a whole frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fb <= '{default: GLYPH_BLANK};
    else if (load && !start) fb <= imm_fb;
    else if (commit) fb <= dec_fb;
  // slot counter and rotating digit index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot <= '0;
      idx <= '0;
    end else begin
      slot <= slot == SW'(REFRESH_DIV - 1) ? '0 : slot + 1'b1;
      if (slot == SW'(REFRESH_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    end
  assign lit = slot >= SW'(GUARD);
  assign dig_raw = lit ? DIGITS'(1) << idx : '0;
  assign seg_raw = lit ? {1'b0, glyph_to_seg(fb[idx])} : 8'h00;
  // output register, the only place pin polarity is applied
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      digit <= {DIGITS{ACTIVE_LOW}};
      segments <= {8{ACTIVE_LOW}};
    end else begin
      digit <= dig_raw ^ {DIGITS{ACTIVE_LOW}};
      segments <= seg_raw ^ {8{ACTIVE_LOW}};
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed stimulus checked every cycle against a behavioural display model
module tb_seven_seg_scanner;
  localparam int W = 8, D = 4, R = 4, G = 1;
  localparam int MINUS = 16, BLANK = 17;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, busy;
  logic [W-1:0] value = '0;
  logic [1:0] mode = '0;
  logic [D-1:0] digit;
  logic [7:0] segments;
  int checks = 0, errors = 0;
  int seg_tab [18] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F,
                       'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71, 'h40, 'h00};
  logic [3:0] scan_tab [18] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
  int m_fb [D], m_prev [D];
  int m_n, m_rem, m_mag, e_i;
  bit m_busy, m_neg;
  logic [3:0] e_d;
  logic [7:0] e_s;

  seven_seg_scanner #(.DATA_WIDTH(W), .DIGITS(D), .REFRESH_DIV(R), .GUARD(G), .ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .mode     (mode),
    .busy     (busy),
    .digit    (digit),
    .segments (segments)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_busy = 0;
    m_rem = 0;
    for (int i = 0; i < D; i++) begin
      m_fb[i] = BLANK;
      m_prev[i] = BLANK;
    end
  endtask

  task automatic model_commit();
    int t, nd;
    t = m_mag;
    nd = 0;
    for (int i = 0; i < D; i++) m_fb[i] = BLANK;
    do begin
      m_fb[nd] = t % 10;
      t = t / 10;
      nd++;
    end while (t > 0);
    if (m_neg) m_fb[nd] = MINUS;
  endtask

  task automatic model_step();
    m_prev = m_fb;
    m_n++;
    if (load) begin
      m_busy = 0;
      if (mode == 2'd2)
        for (int i = 0; i < D; i++) m_fb[i] = i < (W + 3) / 4 ? (int'(value) >> (4 * i)) & 15 : BLANK;
      else if (mode == 2'd3)
        for (int i = 0; i < D; i++) m_fb[i] = BLANK;
      else begin
        m_neg = mode == 2'd1 && int'(value) >= 2 ** (W - 1);
        m_mag = m_neg ? 2 ** W - int'(value) : int'(value);
        m_busy = 1;
        m_rem = W - 1;
      end
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        model_commit();
        m_busy = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    e_d = 4'hF;
    e_s = 8'hFF;
    if (rst_n && m_n > 0 && (m_n - 1) % R >= G) begin
      e_i = ((m_n - 1) / R) % D;
      e_d = ~(4'b0001 << e_i);
      e_s = ~{1'b0, 7'(seg_tab[m_prev[e_i]])};
    end
    chk("cyc_busy", busy, rst_n ? 32'(m_busy) : 32'd0);
    chk("cyc_digit", digit, e_d);
    chk("cyc_segments", segments, e_s);
  end

  task automatic do_load(input int v, input int md);
    @(negedge clk);
    load = 1'b1;
    value = W'(v);
    mode = 2'(md);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_model(input string name, input int g3, input int g2, input int g1, input int g0);
    chk({name, "_m3"}, m_fb[3], g3);
    chk({name, "_m2"}, m_fb[2], g2);
    chk({name, "_m1"}, m_fb[1], g1);
    chk({name, "_m0"}, m_fb[0], g0);
  endtask

  task automatic check_screen(input string name, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
    logic [7:0] got [D];
    logic [7:0] e [D];
    bit seen [D];
    e[0] = s0;
    e[1] = s1;
    e[2] = s2;
    e[3] = s3;
    for (int i = 0; i < D; i++) begin
      seen[i] = 0;
      got[i] = '0;
    end
    for (int c = 0; c < 4 * R * D && !(seen[0] && seen[1] && seen[2] && seen[3]); c++) begin
      @(negedge clk);
      for (int i = 0; i < D; i++) if (!digit[i]) begin
        got[i] = segments;
        seen[i] = 1;
      end
    end
    for (int i = 0; i < D; i++)
      chk($sformatf("%s_d%0d", name, i), seen[i] ? 32'(got[i]) : 32'h100, 32'(e[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_digit", digit, 4'hF);
    chk("rst_segments", segments, 8'hFF);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("scan%0d", k), digit, scan_tab[k]);
    end
    do_load(200, 0);
    chk("u200_busy", busy, 1);
    repeat (W + 2) @(negedge clk);
    check_model("u200", BLANK, 2, 0, 0);
    check_screen("u200", 8'hFF, 8'hA4, 8'hC0, 8'hC0);
    do_load('h80, 1);
    repeat (W + 2) @(negedge clk);
    check_model("s128", MINUS, 1, 2, 8);
    check_screen("s128", 8'hBF, 8'hF9, 8'hA4, 8'h80);
    do_load('hFB, 1);
    repeat (W + 2) @(negedge clk);
    check_model("s5", BLANK, BLANK, MINUS, 5);
    check_screen("s5", 8'hFF, 8'hFF, 8'hBF, 8'h92);
    do_load(0, 1);
    repeat (W + 2) @(negedge clk);
    check_model("s0", BLANK, BLANK, BLANK, 0);
    check_screen("s0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    do_load(255, 0);
    repeat (W + 2) @(negedge clk);
    check_screen("u255", 8'hFF, 8'hA4, 8'h92, 8'h92);
    do_load('hA7, 2);
    chk("hex_busy", busy, 0);
    check_model("hexA7", BLANK, BLANK, 10, 7);
    check_screen("hexA7", 8'hFF, 8'hFF, 8'h88, 8'hF8);
    do_load(99, 0);
    repeat (2) @(negedge clk);
    do_load(5, 0);
    repeat (W + 2) @(negedge clk);
    check_model("restart", BLANK, BLANK, BLANK, 5);
    check_screen("restart", 8'hFF, 8'hFF, 8'hFF, 8'h92);
    do_load(77, 0);
    repeat (5) @(negedge clk);
    do_load(31, 0);
    chk("final_step_busy", busy, 1);
    repeat (W + 2) @(negedge clk);
    check_model("final_step", BLANK, BLANK, 3, 1);
    check_screen("final_step", 8'hFF, 8'hFF, 8'hB0, 8'hF9);
    do_load(123, 0);
    repeat (2) @(negedge clk);
    do_load('h3C, 2);
    chk("abort_busy", busy, 0);
    repeat (W + 4) @(negedge clk);
    check_model("abort", BLANK, BLANK, 3, 12);
    check_screen("abort", 8'hFF, 8'hFF, 8'hB0, 8'hC6);
    do_load(0, 3);
    check_screen("blank", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    do_load(250, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_digit", digit, 4'hF);
    chk("midrst_segments", segments, 8'hFF);
    chk("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check_model("midrst", BLANK, BLANK, BLANK, BLANK);
    check_screen("midrst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
